// File: rtl/word6_fifo.sv
// word6_fifo: 4-entry, 6-bit ready/valid FIFO with registered flags and a zeroed output when empty.
// Optional occupancy port is enabled with macro WORD6_FIFO_LEVEL_EN.
module word6_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef WORD6_FIFO_LEVEL_EN
    ,
    output logic [2:0]       level
`endif
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic             push, pop;

    // Flags come from the registered count only, so a pop never frees a slot in the same cycle.
    assign in_ready  = (count_q != 3'(DEPTH));
    assign out_valid = (count_q != 3'd0);
    assign out       = out_valid ? mem_q[rd_ptr_q] : '0;

`ifdef WORD6_FIFO_LEVEL_EN
    assign level = count_q;
`endif

    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        wr_ptr_d = wr_ptr_q + 2'(push);
        rd_ptr_d = rd_ptr_q + 2'(pop);
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 3'd1;
        end else if (pop && !push) begin
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

endmodule

// File: tb/tb_word6_fifo.sv
// Bench for word6_fifo: directed and random steps checked against a queue-based model.
module tb_word6_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] din = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] dout;
    logic       out_valid;
    logic       out_ready = 1'b0;
`ifdef WORD6_FIFO_LEVEL_EN
    logic [2:0] level;
`endif

    word6_fifo #(.WIDTH(6), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (dout),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef WORD6_FIFO_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [5:0] q[$];      // model contents, head at index 0
    logic [5:0] seen[$];   // DUT words observed at each pop
    logic       acc;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs to the model, then advance the model across the edge.
    task automatic cyc(input logic r, input logic iv, input logic [5:0] d, input logic ordy,
                       output logic accepted);
        logic       do_push, do_pop;
        logic [5:0] head;
        @(negedge clk);
        rst = r; in_valid = iv; din = d; out_ready = ordy;
        #1;
        head = (q.size() != 0) ? q[0] : 6'h00;
        chk("out_valid", {7'd0, out_valid}, {7'd0, q.size() != 0});
        chk("in_ready",  {7'd0, in_ready},  {7'd0, q.size() != 4});
        chk("out",       {2'd0, dout},      {2'd0, head});
`ifdef WORD6_FIFO_LEVEL_EN
        chk("level",     {5'd0, level},     8'(q.size()));
`endif
        do_push = iv && (q.size() != 4);
        do_pop  = ordy && (q.size() != 0);
        @(posedge clk);
        if (r) begin
            q.delete();
            accepted = 1'b0;
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                seen.push_back(dout);
            end
            if (do_push) q.push_back(d);
            accepted = do_push;
        end
    endtask

    initial begin
        // Reset
        cyc(1, 0, 0, 0, acc);
        cyc(1, 1, 6'h3F, 1, acc);
        cyc(0, 0, 0, 0, acc);

        // Single push of 2A, observe next cycle, then pop
        cyc(0, 1, 6'h2A, 0, acc);
        cyc(0, 0, 0, 0, acc);
        cyc(0, 0, 0, 1, acc);
        cyc(0, 0, 0, 1, acc);   // pop while empty has no effect

        // Fill to four, fifth push held off
        seen.delete();
        for (int i = 1; i <= 4; i++) cyc(0, 1, 6'(i), 0, acc);
        cyc(0, 1, 6'h05, 0, acc);
        chk("held_push", {7'd0, acc}, 8'd0);
        // Full: push and pop together -> only the pop happens
        cyc(0, 1, 6'h05, 1, acc);
        chk("full_pushpop", {7'd0, acc}, 8'd0);
        cyc(0, 0, 0, 1, acc);
        cyc(0, 0, 0, 1, acc);
        cyc(0, 0, 0, 1, acc);
        cyc(0, 0, 0, 0, acc);
        chk("pop_count", 8'(seen.size()), 8'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++) chk("pop_order", {2'd0, seen[i]}, 8'(i + 1));

        // Level 2, ten cycles of simultaneous push/pop
        cyc(0, 1, 6'h0E, 0, acc);
        cyc(0, 1, 6'h0F, 0, acc);
        for (int i = 0; i < 10; i++) cyc(0, 1, 6'(8'h10 + i), 1, acc);
        cyc(0, 0, 0, 0, acc);
        chk("stream_level", 8'(q.size()), 8'd2);
        while (q.size() != 0) cyc(0, 0, 0, 1, acc);

        // Fill to three, reset during push+pop
        for (int i = 0; i < 3; i++) cyc(0, 1, 6'(8'h20 + i), 0, acc);
        cyc(1, 1, 6'h33, 1, acc);
        cyc(0, 0, 0, 0, acc);

        // All 64 values through with random downstream ready
        seen.delete();
        begin
            int v = 0;
            int budget = 2000;
            while (v < 64 && budget > 0) begin
                cyc(0, 1, 6'(v), 1'($urandom_range(0, 1)), acc);
                if (acc) v++;
                budget--;
            end
            for (int i = 0; i < 10 && q.size() != 0; i++) cyc(0, 0, 0, 1, acc);
            chk("sweep_done", 8'(v), 8'd64);
        end
        chk("sweep_count", 8'(seen.size()), 8'd64);
        for (int i = 0; i < 64 && i < seen.size(); i++) begin
            logic [5:0] inv_obs, inv_exp;
            inv_obs = ~seen[i];
            inv_exp = ~6'(i);
            chk("inverter", {2'd0, inv_obs}, {2'd0, inv_exp});
        end

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0), 1'($urandom), 6'($urandom), 1'($urandom), acc);
        end
        cyc(0, 0, 0, 0, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
